// File: rtl/parser_rule_cfg_pkg.sv
// Shared types and address-map constants for the parser rule configuration agent.
// No logic here: field/state enums and bit positions used by decode and top.
package parser_cfg_pkg;

    localparam int STAGE_LSB = 16;
    localparam int STAGE_MSB = 19;
    localparam int SPACE_BIT = 15;
    localparam int FIELD_LSB = 8;
    localparam int FIELD_MSB = 10;

    localparam logic [31:0] ERR_CLR_ADDR = 32'h000F_8000;

    typedef enum logic [2:0] {
        CFG_COMMIT = 3'd0,
        CFG_TYPE   = 3'd1,
        CFG_KEY    = 3'd2,
        CFG_HSHIFT = 3'd3,
        CFG_MSHIFT = 3'd4
    } cfg_field_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE
    } cfg_state_e;

endpackage

// File: rtl/parser_rule_cfg_if.sv
// Register-style config bus: valid/ready request, one-cycle read strobe, sticky error.
// Master drives requests and is held off while ready is low.
interface parser_rule_cfg_if;
    logic        i_cfg_valid;
    logic        i_cfg_wr;
    logic [31:0] i_cfg_addr;
    logic [31:0] i_cfg_wdata;
    logic        o_cfg_ready;
    logic        o_cfg_rvalid;
    logic [31:0] o_cfg_rdata;
    logic        o_cfg_err;

    modport master (
        output i_cfg_valid, i_cfg_wr, i_cfg_addr, i_cfg_wdata,
        input  o_cfg_ready, o_cfg_rvalid, o_cfg_rdata, o_cfg_err
    );

    modport slave (
        input  i_cfg_valid, i_cfg_wr, i_cfg_addr, i_cfg_wdata,
        output o_cfg_ready, o_cfg_rvalid, o_cfg_rdata, o_cfg_err
    );
endinterface

// File: rtl/parser_rule_cfg_decode.sv
// Combinational config-address decode and legality check.
// Zero latency; no flow control of its own.
module parser_cfg_decode
    import parser_cfg_pkg::*;
#(
    parameter int STAGE_NUM     = 4,
    parameter int RULE_NUM      = 16,
    parameter int TYPE_NUM      = 4,
    parameter int KEY_FIELD_NUM = 8
) (
    input  logic [31:0] addr,
    output cfg_field_e  field,
    output logic [3:0]  stage,
    output logic [5:0]  index,
    output logic        type_offset_sel,
    output logic        illegal
);

    always_comb begin
        field           = cfg_field_e'(addr[FIELD_MSB:FIELD_LSB]);
        stage           = addr[STAGE_MSB:STAGE_LSB];
        type_offset_sel = addr[SPACE_BIT];
        index           = (type_offset_sel || field == CFG_TYPE) ? {2'b00, addr[3:0]} : addr[5:0];
        illegal         = 1'b0;

        if (32'(stage) >= STAGE_NUM)
            illegal = 1'b1;

        if (type_offset_sel) begin
            if (32'(index) >= TYPE_NUM) illegal = 1'b1;
        end else begin
            case (field)
                CFG_COMMIT: if (32'(index) >= RULE_NUM)      illegal = 1'b1;
                CFG_TYPE:   if (32'(index) >= TYPE_NUM)      illegal = 1'b1;
                CFG_KEY:    if (32'(index) >= KEY_FIELD_NUM) illegal = 1'b1;
                CFG_HSHIFT, CFG_MSHIFT: ;
                default:    illegal = 1'b1;
            endcase
        end

        // The error-clear address sits in stage 15 but is always accepted.
        if (addr == ERR_CLR_ADDR)
            illegal = 1'b0;
    end

endmodule

// File: rtl/parser_rule_cfg.sv
// Stages rule fields into a shadow image and commits it atomically to one parser stage.
// Reads return 1 cycle after accept; a commit holds ready low for 2 cycles (strobe at N+2).
module parser_rule_cfg
    import parser_cfg_pkg::*;
#(
    parameter int STAGE_NUM         = 4,
    parameter int RULE_NUM          = 16,
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FIELD_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 6,
    parameter int HEAD_SHIFT_WIDTH  = 6,
    parameter int META_SHIFT_WIDTH  = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    parser_rule_cfg_if.slave         cfg,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] o_type_offset,
    output logic [STAGE_NUM-1:0][RULE_NUM-1:0]                        o_rule_wren,
    output logic                                                      o_rule_valid,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                       o_rule_typeData,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                       o_rule_typeMask,
    output logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0]              o_rule_keyOffset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                               o_rule_headShift,
    output logic [META_SHIFT_WIDTH-1:0]                               o_rule_metaShift
);

    localparam int SW = (STAGE_NUM > 1)     ? $clog2(STAGE_NUM)     : 1;
    localparam int RW = (RULE_NUM > 1)      ? $clog2(RULE_NUM)      : 1;
    localparam int TW = (TYPE_NUM > 1)      ? $clog2(TYPE_NUM)      : 1;
    localparam int KW = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

    cfg_field_e field;
    logic [3:0] stage;
    logic [5:0] index;
    logic       off_sel, illegal;

    parser_cfg_decode #(
        .STAGE_NUM     (STAGE_NUM),
        .RULE_NUM      (RULE_NUM),
        .TYPE_NUM      (TYPE_NUM),
        .KEY_FIELD_NUM (KEY_FIELD_NUM)
    ) u_decode (
        .addr            (cfg.i_cfg_addr),
        .field           (field),
        .stage           (stage),
        .index           (index),
        .type_offset_sel (off_sel),
        .illegal         (illegal)
    );

    cfg_state_e state, state_nxt;
    logic ready_q, accept, clr_hit, wr_ok, commit_acc, load_en;
    logic err_q, rvalid_q;
    logic [31:0] rdata_q, rd_nxt;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          sh_tdata, sh_tmask;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0] sh_key;
    logic [KEY_OFFSET_WIDTH:0]                    key_sel;
    logic [HEAD_SHIFT_WIDTH-1:0]                  sh_hs;
    logic [META_SHIFT_WIDTH-1:0]                  sh_ms;
    logic [SW-1:0] cm_stage;
    logic [RW-1:0] cm_rule;
    logic          cm_valid;
    logic          unused_bits;

    assign unused_bits = ^{stage, index};

    assign accept     = cfg.i_cfg_valid & ready_q;
    assign clr_hit    = (cfg.i_cfg_addr == ERR_CLR_ADDR);
    assign wr_ok      = accept & cfg.i_cfg_wr & ~illegal & ~clr_hit;
    assign commit_acc = wr_ok & ~off_sel & (field == CFG_COMMIT);

    assign cfg.o_cfg_ready  = ready_q;
    assign cfg.o_cfg_rvalid = rvalid_q;
    assign cfg.o_cfg_rdata  = rdata_q;
    assign cfg.o_cfg_err    = err_q;

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        case (state)
            ST_IDLE:   if (commit_acc) state_nxt = ST_LOAD;
            ST_LOAD:   begin load_en = 1'b1; state_nxt = ST_STROBE; end
            ST_STROBE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Ready is registered from the next state so it rises one cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_type_offset <= '0;
            sh_tdata      <= '0;
            sh_tmask      <= '0;
            sh_key        <= '0;
            sh_hs         <= '0;
            sh_ms         <= '0;
            cm_stage      <= '0;
            cm_rule       <= '0;
            cm_valid      <= 1'b0;
        end else if (wr_ok) begin
            if (off_sel) begin
                o_type_offset[stage[SW-1:0]][index[TW-1:0]] <= cfg.i_cfg_wdata[TYPE_OFFSET_WIDTH-1:0];
            end else begin
                case (field)
                    CFG_COMMIT: begin
                        cm_stage <= stage[SW-1:0];
                        cm_rule  <= index[RW-1:0];
                        cm_valid <= cfg.i_cfg_wdata[0];
                    end
                    CFG_TYPE: begin
                        sh_tdata[index[TW-1:0]] <= TYPE_WIDTH'(cfg.i_cfg_wdata[31:16]);
                        sh_tmask[index[TW-1:0]] <= TYPE_WIDTH'(cfg.i_cfg_wdata[15:0]);
                    end
                    CFG_KEY:    sh_key[index[KW-1:0]] <= {cfg.i_cfg_wdata[16], cfg.i_cfg_wdata[KEY_OFFSET_WIDTH-1:0]};
                    CFG_HSHIFT: sh_hs <= cfg.i_cfg_wdata[HEAD_SHIFT_WIDTH-1:0];
                    CFG_MSHIFT: sh_ms <= cfg.i_cfg_wdata[META_SHIFT_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rule_wren      <= '0;
            o_rule_valid     <= 1'b0;
            o_rule_typeData  <= '0;
            o_rule_typeMask  <= '0;
            o_rule_keyOffset <= '0;
            o_rule_headShift <= '0;
            o_rule_metaShift <= '0;
        end else begin
            o_rule_wren <= '0;
            if (load_en) begin
                o_rule_wren[cm_stage][cm_rule] <= 1'b1;
                o_rule_valid     <= cm_valid;
                o_rule_typeData  <= sh_tdata;
                o_rule_typeMask  <= sh_tmask;
                o_rule_keyOffset <= sh_key;
                o_rule_headShift <= sh_hs;
                o_rule_metaShift <= sh_ms;
            end
        end
    end

    assign key_sel = sh_key[index[KW-1:0]];

    always_comb begin
        rd_nxt = '0;
        if (!illegal && !clr_hit) begin
            if (off_sel) begin
                rd_nxt = 32'(o_type_offset[stage[SW-1:0]][index[TW-1:0]]);
            end else begin
                case (field)
                    CFG_COMMIT: rd_nxt = {31'b0, o_rule_valid};
                    CFG_TYPE:   rd_nxt = (32'(sh_tdata[index[TW-1:0]]) << 16) | 32'(sh_tmask[index[TW-1:0]]);
                    CFG_KEY:    rd_nxt = (32'(key_sel[KEY_OFFSET_WIDTH]) << 16) | 32'(key_sel[KEY_OFFSET_WIDTH-1:0]);
                    CFG_HSHIFT: rd_nxt = 32'(sh_hs);
                    CFG_MSHIFT: rd_nxt = 32'(sh_ms);
                    default:    rd_nxt = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= accept & ~cfg.i_cfg_wr;
            if (accept & ~cfg.i_cfg_wr)
                rdata_q <= rd_nxt;
            if (accept) begin
                if (illegal)
                    err_q <= 1'b1;
                else if (clr_hit && cfg.i_cfg_wr && cfg.i_cfg_wdata[0])
                    err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parser_rule_cfg.sv
// Directed bench for parser_rule_cfg: register vector table plus commit/reset sequences.
module tb_parser_rule_cfg;

    localparam int STAGE_NUM = 4, RULE_NUM = 16, TYPE_NUM = 4, TYPE_WIDTH = 16;
    localparam int TYPE_OFFSET_WIDTH = 8, KEY_FIELD_NUM = 8, KEY_OFFSET_WIDTH = 6;
    localparam int HEAD_SHIFT_WIDTH = 6, META_SHIFT_WIDTH = 6;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    parser_rule_cfg_if cfg_bus ();

    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_offset;
    logic [STAGE_NUM-1:0][RULE_NUM-1:0]                        rule_wren;
    logic                                                      rule_valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                       rule_tdata, rule_tmask;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0]              rule_key;
    logic [HEAD_SHIFT_WIDTH-1:0]                               rule_hs;
    logic [META_SHIFT_WIDTH-1:0]                               rule_ms;

    parser_rule_cfg #(
        .STAGE_NUM(STAGE_NUM), .RULE_NUM(RULE_NUM), .TYPE_NUM(TYPE_NUM),
        .TYPE_WIDTH(TYPE_WIDTH), .TYPE_OFFSET_WIDTH(TYPE_OFFSET_WIDTH),
        .KEY_FIELD_NUM(KEY_FIELD_NUM), .KEY_OFFSET_WIDTH(KEY_OFFSET_WIDTH),
        .HEAD_SHIFT_WIDTH(HEAD_SHIFT_WIDTH), .META_SHIFT_WIDTH(META_SHIFT_WIDTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .cfg              (cfg_bus),
        .o_type_offset    (type_offset),
        .o_rule_wren      (rule_wren),
        .o_rule_valid     (rule_valid),
        .o_rule_typeData  (rule_tdata),
        .o_rule_typeMask  (rule_tmask),
        .o_rule_keyOffset (rule_key),
        .o_rule_headShift (rule_hs),
        .o_rule_metaShift (rule_ms)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Returns #1 after the accepting edge with valid already dropped.
    task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        cfg_bus.i_cfg_valid = 1'b1;
        cfg_bus.i_cfg_wr    = wr;
        cfg_bus.i_cfg_addr  = addr;
        cfg_bus.i_cfg_wdata = wdata;
        while (!cfg_bus.o_cfg_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);
        tick();
        cfg_bus.i_cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0002_8003, 32'h0000_002A, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 32'h0002_8003, 32'h0,         32'h0000_002A, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0101, 32'h0800_FFFF, 32'h0,          1'b0};
        vecs[3]  = '{1'b0, 32'h0003_0101, 32'h0,         32'h0800_FFFF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0202, 32'h0001_000E, 32'h0,          1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0202, 32'h0,         32'h0001_000E, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0300, 32'hFFFF_FFE5, 32'h0,          1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0300, 32'h0,         32'h0000_0025, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0,          1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0011, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,          1'b0};
        vecs[11] = '{1'b1, 32'h0005_8003, 32'h0000_0055, 32'h0,          1'b1};
        vecs[12] = '{1'b0, 32'h0002_8003, 32'h0,         32'h0000_002A, 1'b1};
        vecs[13] = '{1'b1, 32'h000F_8000, 32'h0000_0001, 32'h0,          1'b0};
        vecs[14] = '{1'b1, 32'h0000_0014, 32'h0000_0001, 32'h0,          1'b1};
        vecs[15] = '{1'b1, 32'h000F_8000, 32'h0000_0001, 32'h0,          1'b0};
        vecs[16] = '{1'b1, 32'h0000_0600, 32'hFFFF_FFFF, 32'h0,          1'b1};
        vecs[17] = '{1'b0, 32'h0000_0600, 32'h0,         32'h0,          1'b1};
        vecs[18] = '{1'b0, 32'h0000_0104, 32'h0,         32'h0,          1'b1};
        vecs[19] = '{1'b1, 32'h000F_8000, 32'h0000_0000, 32'h0,          1'b1};
        vecs[20] = '{1'b1, 32'h000F_8000, 32'h0000_0001, 32'h0,          1'b0};
        vecs[21] = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,          1'b1};
        vecs[22] = '{1'b0, 32'h0000_0101, 32'h0,         32'h0800_FFFF, 1'b1};
        vecs[23] = '{1'b1, 32'h000F_8000, 32'h0000_0001, 32'h0,          1'b0};

        cfg_bus.i_cfg_valid = 1'b0;
        cfg_bus.i_cfg_wr    = 1'b0;
        cfg_bus.i_cfg_addr  = '0;
        cfg_bus.i_cfg_wdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_type_offset", 128'(type_offset), 128'd0);
        chk("rst_wren", 128'(rule_wren), 128'd0);
        chk("rst_ready", {127'b0, cfg_bus.o_cfg_ready}, 128'd0);
        chk("rst_rvalid", {127'b0, cfg_bus.o_cfg_rvalid}, 128'd0);
        chk("rst_rdata", 128'(cfg_bus.o_cfg_rdata), 128'd0);
        chk("rst_err", {127'b0, cfg_bus.o_cfg_err}, 128'd0);
        chk("rst_payload", 128'({rule_valid, rule_tdata, rule_hs, rule_ms}), 128'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rst_ready_after", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);

        for (int i = 0; i < NV; i++) begin
            req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].wr) begin
                chk($sformatf("vec%0d_rvalid", i), {127'b0, cfg_bus.o_cfg_rvalid}, 128'd1);
                chk($sformatf("vec%0d_rdata", i), 128'(cfg_bus.o_cfg_rdata), 128'(vecs[i].exp_rdata));
            end
            chk($sformatf("vec%0d_err", i), {127'b0, cfg_bus.o_cfg_err}, {127'b0, vecs[i].exp_err});
        end
        chk("offset_image", 128'(type_offset), 128'h2A << 88);
        chk("no_commit_ready", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);
        chk("no_commit_wren", 128'(rule_wren), 128'd0);

        // Back-to-back reads give back-to-back rvalid
        cfg_bus.i_cfg_valid = 1'b1;
        cfg_bus.i_cfg_wr    = 1'b0;
        cfg_bus.i_cfg_addr  = 32'h0000_0300;
        tick();
        cfg_bus.i_cfg_addr  = 32'h0000_0400;
        chk("b2b_rd0", 128'({cfg_bus.o_cfg_rvalid, cfg_bus.o_cfg_rdata}), 128'h1_0000_0025);
        tick();
        cfg_bus.i_cfg_valid = 1'b0;
        chk("b2b_rd1", 128'({cfg_bus.o_cfg_rvalid, cfg_bus.o_cfg_rdata}), 128'h1_0000_0011);
        tick();
        chk("b2b_idle", {127'b0, cfg_bus.o_cfg_rvalid}, 128'd0);

        // Commit stage 1 rule 5 with a write held pending throughout
        cfg_bus.i_cfg_valid = 1'b1;
        cfg_bus.i_cfg_wr    = 1'b1;
        cfg_bus.i_cfg_addr  = 32'h0001_0005;
        cfg_bus.i_cfg_wdata = 32'h0000_0001;
        chk("c1_ready_n", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);
        tick();
        cfg_bus.i_cfg_addr  = 32'h0000_0101;
        cfg_bus.i_cfg_wdata = 32'h1234_5678;
        chk("c1_ready_n1", {127'b0, cfg_bus.o_cfg_ready}, 128'd0);
        chk("c1_wren_n1", 128'(rule_wren), 128'd0);
        tick();
        chk("c1_ready_n2", {127'b0, cfg_bus.o_cfg_ready}, 128'd0);
        chk("c1_wren_n2", 128'(rule_wren), 128'd1 << 21);
        chk("c1_valid", {127'b0, rule_valid}, 128'd1);
        chk("c1_tdata1", 128'(rule_tdata[1]), 128'h0800);
        chk("c1_tmask1", 128'(rule_tmask[1]), 128'hFFFF);
        chk("c1_tdata0", 128'(rule_tdata[0]), 128'h0);
        chk("c1_key2", 128'(rule_key[2]), 128'h4E);
        chk("c1_key0", 128'(rule_key[0]), 128'h0);
        chk("c1_shifts", 128'({rule_hs, rule_ms}), 128'h951);
        tick();
        chk("c1_ready_n3", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);
        chk("c1_wren_n3", 128'(rule_wren), 128'd0);
        tick();
        cfg_bus.i_cfg_valid = 1'b0;
        chk("c1_payload_held", 128'(rule_tdata[1]), 128'h0800);
        req(1'b0, 32'h0000_0101, 32'h0);
        chk("c1_late_write", 128'(cfg_bus.o_cfg_rdata), 128'h1234_5678);
        req(1'b0, 32'h0000_0000, 32'h0);
        chk("c1_read_valid", 128'(cfg_bus.o_cfg_rdata), 128'd1);

        // Commit stage 3 rule 15 with valid 0
        req(1'b1, 32'h0003_000F, 32'h0000_0000);
        tick();
        chk("c2_wren", 128'(rule_wren), 128'd1 << 63);
        chk("c2_valid", {127'b0, rule_valid}, 128'd0);
        chk("c2_type1", 128'({rule_tdata[1], rule_tmask[1]}), 128'h1234_5678);
        tick();
        chk("c2_wren_off", 128'(rule_wren), 128'd0);
        chk("c2_hold", 128'({rule_tdata[1], rule_tmask[1]}), 128'h1234_5678);

        // Reset asserted during STROBE
        req(1'b1, 32'h0000_0000, 32'h0000_0001);
        tick();
        chk("c3_wren", 128'(rule_wren), 128'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("c3_wren_async", 128'(rule_wren), 128'd0);
        chk("c3_ready_rst", {127'b0, cfg_bus.o_cfg_ready}, 128'd0);
        chk("c3_payload_rst", 128'({rule_valid, rule_tdata}), 128'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("c3_ready_idle", {127'b0, cfg_bus.o_cfg_ready}, 128'd1);
        tick();
        chk("c3_wren_idle", 128'(rule_wren), 128'd0);
        req(1'b0, 32'h0000_0101, 32'h0);
        chk("c3_shadow_cleared", 128'(cfg_bus.o_cfg_rdata), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parser_rule_cfg.md
# parser_rule_cfg

Multi-stage, parametrised rule-configuration agent for the programmable parser. It decodes a 32-bit register-style config bus and stages rule fields into a shadow image. On a commit command it broadcasts that image, atomically, to one selected parser stage, together with a one-hot rule write strobe. It adds three things: per-stage type-offset tables, handshaked writes, and registered read-back of the shadow and offset state.

## Interface
- `STAGE_NUM`, 4: parser stages served.
- `RULE_NUM`, 16: rule slots per stage.
- `TYPE_NUM`, 4: type fields per rule.
- `TYPE_WIDTH`, 16: type data/mask width.
- `TYPE_OFFSET_WIDTH`, 8: per-type offset width.
- `KEY_FIELD_NUM`, 8: key-offset fields per rule.
- `KEY_OFFSET_WIDTH`, 6: key offset width; the stored value adds a valid bit on top.
- `HEAD_SHIFT_WIDTH` / `META_SHIFT_WIDTH`, 6 / 6.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_cfg_valid`, in, 1: request valid.
- `i_cfg_wr`, in, 1: 1 = write, 0 = read.
- `i_cfg_addr`, in, 32: request address.
- `i_cfg_wdata`, in, 32: write data.
- `o_cfg_ready`, out, 1: request accepted when valid && ready.
- `o_cfg_rvalid`, out, 1: one-cycle read-data strobe.
- `o_cfg_rdata`, out, 32: read data.
- `o_cfg_err`, out, 1: sticky illegal-access flag.
- `o_type_offset`, out, STAGE_NUM×TYPE_NUM×TYPE_OFFSET_WIDTH: live per-stage offsets.
- `o_rule_wren`, out, STAGE_NUM×RULE_NUM: one-hot commit strobe.
- `o_rule_valid`, `o_rule_typeData`, `o_rule_typeMask`, `o_rule_keyOffset`, `o_rule_headShift`, `o_rule_metaShift`, out, widths as the parameters give: broadcast commit payload.

## Operation
Address map:
- addr[19:16]: stage id.
- addr[15]: 1 = type-offset space, with addr[3:0] the type id.
- addr[15] = 0: rule space, with addr[10:8] selecting the field:
  - 0: commit; addr[5:0] is the rule id; wdata[0] is the valid bit.
  - 1: typeData = wdata[31:16], typeMask = wdata[15:0]; addr[3:0] is the type id.
  - 2: keyOffset = {wdata[16], wdata[KEY_OFFSET_WIDTH-1:0]}; addr[5:0] is the key id.
  - 3: headShift.
  - 4: metaShift.
  - 5–7: reserved.

Rules:
- Rule-space fields 1–4 write a single shadow image shared by all stages. The stage id is ignored for these fields.
- Type-offset writes update `o_type_offset[stage][type]` directly; the new value is visible the next cycle.
- Illegal access sets `o_cfg_err`, and the write is dropped or the read returns 0. Illegal means:
  - stage id ≥ STAGE_NUM,
  - index ≥ the relevant count, or
  - a reserved field.
- `o_cfg_err` is cleared only by writing 1 to wdata[0] at address 0x0000_8000 | (0xF<<16), i.e. stage 15, offset space. That write is itself legal.
- Reads return the shadow or offset value, zero-extended and packed as written. A read of field 0 returns {31'b0, last committed valid}.

FSM (IDLE, LOAD, STROBE):
- IDLE: `o_cfg_ready` = 1.
- A legal commit accepted in IDLE goes to LOAD. LOAD copies the shadow image and the valid bit into the `o_rule_*` payload registers and latches the stage and rule ids.
- STROBE: `o_rule_wren[stage][rule]` = 1 for exactly one cycle, while the payload is stable. Then return to IDLE.
- `o_cfg_ready` = 0 in LOAD and STROBE. Requests presented then are held off, not lost.
- The payload holds its value after STROBE until the next LOAD. Shadow writes never disturb a payload being strobed.

## Timing
- Reset: every output and all shadow/offset state go to 0; the FSM goes to IDLE; `o_cfg_ready` = 1 one cycle after deassertion.
- Write: applied at the accepting edge.
- Read: `o_cfg_rvalid`/`o_cfg_rdata` are registered and appear one cycle after acceptance. Back-to-back reads give back-to-back rvalid.
- Commit: accept at cycle N, LOAD at N+1, `o_rule_wren` high during N+2, ready again at N+3. The minimum commit-to-commit spacing is therefore 3 cycles.
- Reset asserted mid-commit: the strobe is aborted and `o_rule_wren` is forced to 0 asynchronously.
- A write during accept updates the shadow in the same edge as an earlier commit's LOAD cannot occur, because ready is low.

## Structure
- Package `parser_cfg_pkg`:
  - field-select enum (`CFG_COMMIT`, `CFG_TYPE`, `CFG_KEY`, `CFG_HSHIFT`, `CFG_MSHIFT`);
  - address bit-position constants;
  - FSM state enum;
  - the error-clear address.
- Sub-module `parser_cfg_decode`: combinational address decode plus legality check. It outputs field, stage, index, type_offset_sel and illegal.

## Test plan
1. **Reset.** Reset with STAGE_NUM=4, then release. Required: all outputs 0, `o_cfg_ready` = 1.
2. **Offset write and read.** Write 0x2A to stage 2, type 3 offset, then read the same address. Required: `o_type_offset[2][3]` = 0x2A next cycle; rvalid one cycle after the read with rdata = 0x2A.
3. **Commit.** Write typeData/Mask 0x0800/0xFFFF to type 1, and key 2 = {1, 6'd14}, then commit stage 1, rule 5, valid 1. Required: `o_rule_wren[1][5]` high for exactly one cycle, 2 cycles after accept, with matching payload; ready low for 2 cycles.
4. **Request during commit.** Hold a write valid throughout a commit. Required: it is accepted only at N+3 and the payload is unchanged.
5. **Illegal access and clear.** Access stage 5, rule 20, and field 6. Required: no state change, `o_cfg_err` = 1; then the clear write sets it to 0.
6. **Reset mid-commit.** Assert reset during STROBE. Required: `o_rule_wren` drops to 0 immediately and the FSM returns to IDLE.
